// File: rtl/axil_regtest_pkg.sv
// -----------------------------------------------------------------------------
// axil_regtest_pkg
//
// Purpose:
//   Shared types and constants for the AXI4-Lite register test master:
//   the FSM state enum, error codes, the AXI OKAY response value, the
//   read-data marker reported on a handshake timeout, and the single
//   combinational helper that produces the address and test pattern for
//   a given register index.
//
// Contents:
//   state_t        FSM state encoding
//   ERR_*          values driven on err_code
//   RESP_OKAY      AXI response value for a successful transfer
//   TIMEOUT_RDATA  err_rdata value reported when a handshake times out
//   pattern_t      address/data pair for one register
//   gen_pattern()  address = base + 4*idx, data = seed ^ {4{idx}}
// -----------------------------------------------------------------------------
package axil_regtest_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        NEXT  = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BRESP    = 2'd1;
    localparam logic [1:0] ERR_RRESP    = 2'd2;
    localparam logic [1:0] ERR_DATA_TMO = 2'd3;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0000;

    // The address is carried at 64 bits so the caller can truncate it to
    // whatever AXI address width it uses; truncation gives the required
    // modulo-2^width wrap.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } pattern_t;

    function automatic pattern_t gen_pattern(
        input logic [63:0] base,
        input logic [31:0] seed,
        input logic [7:0]  idx
    );
        pattern_t p;
        p.addr = base + {54'd0, idx, 2'b00};
        p.data = seed ^ {4{idx}};
        return p;
    endfunction

endpackage

// File: rtl/axil_regtest_master.sv
// -----------------------------------------------------------------------------
// axil_regtest_master
//
// Purpose:
//   AXI4-Lite master that walks C_NUM_REGS consecutive 32-bit registers,
//   writing a seed-derived pattern to each and reading it back. The first
//   bad response, data mismatch or handshake timeout aborts the run and is
//   reported through err_code / err_index / err_rdata. Only one transaction
//   is ever outstanding, and reads never overlap writes.
//
// Ports:
//   M00_AXI_ACLK      clock
//   M00_AXI_ARESETN   asynchronous active-low reset
//   start             one-cycle pulse, accepted only while idle
//   seed              pattern seed, sampled when start is accepted
//   busy              high from start acceptance until the done cycle
//   done              one-cycle pulse at the end of a run
//   pass              result of the last run (valid from done to next start)
//   err_code          0 none, 1 bad BRESP, 2 bad RRESP, 3 mismatch/timeout
//   err_index         register index of the first failure
//   err_rdata         read data captured at the first failure
//   M00_AXI_AW*/W*/B*/AR*/R*   AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_regtest_master
    import axil_regtest_pkg::*;
#(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = '0,
    parameter int                          C_NUM_REGS         = 4,
    parameter int                          C_TIMEOUT          = 255
) (
    input  logic                            M00_AXI_ACLK,
    input  logic                            M00_AXI_ARESETN,

    input  logic                            start,
    input  logic [31:0]                     seed,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [1:0]                      err_code,
    output logic [7:0]                      err_index,
    output logic [31:0]                     err_rdata,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M00_AXI_AWADDR,
    output logic [2:0]                      M00_AXI_AWPROT,
    output logic                            M00_AXI_AWVALID,
    input  logic                            M00_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M00_AXI_WDATA,
    output logic [3:0]                      M00_AXI_WSTRB,
    output logic                            M00_AXI_WVALID,
    input  logic                            M00_AXI_WREADY,

    input  logic [1:0]                      M00_AXI_BRESP,
    input  logic                            M00_AXI_BVALID,
    output logic                            M00_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M00_AXI_ARADDR,
    output logic [2:0]                      M00_AXI_ARPROT,
    output logic                            M00_AXI_ARVALID,
    input  logic                            M00_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M00_AXI_RDATA,
    input  logic [1:0]                      M00_AXI_RRESP,
    input  logic                            M00_AXI_RVALID,
    output logic                            M00_AXI_RREADY
);

    // The counter only has to reach C_TIMEOUT-1: the cycle in which it sits
    // at that value is the last one allowed before the run is aborted.
    localparam int TMO_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [31:0]        seed_q, seed_d;
    logic               aw_pend_q, aw_pend_d;
    logic               w_pend_q, w_pend_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [7:0]         err_index_q, err_index_d;
    logic [31:0]        err_rdata_q, err_rdata_d;
    logic               pass_q, pass_d;

    pattern_t           pat;
    logic               tmo_expired;
    logic               waiting;
    logic               fail_set;
    logic [1:0]         fail_code;
    logic [31:0]        fail_rdata;

    // State register and all other flops. Reset is asynchronous so the
    // master drops every valid/ready at once, even mid-transaction.
    always_ff @(posedge M00_AXI_ACLK or negedge M00_AXI_ARESETN) begin
        if (!M00_AXI_ARESETN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            seed_q      <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            tmo_q       <= '0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            err_rdata_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seed_q      <= seed_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            tmo_q       <= tmo_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            err_rdata_q <= err_rdata_d;
            pass_q      <= pass_d;
        end
    end

    // Next-state logic. Each waiting state either completes its handshake,
    // or, once the timeout counter has run out, raises a failure. Failures
    // are collected into fail_* and applied once after the case so the
    // first error always freezes idx into err_index and heads for FIN.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        tmo_d       = tmo_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        err_rdata_d = err_rdata_q;
        pass_d      = pass_q;
        fail_set    = 1'b0;
        fail_code   = ERR_NONE;
        fail_rdata  = '0;

        pat         = gen_pattern(64'(C_BASE_ADDR), seed_q, idx_q);
        tmo_expired = (tmo_q == TMO_W'(C_TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    seed_d      = seed;
                    aw_pend_d   = 1'b1;
                    w_pend_d    = 1'b1;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                    err_rdata_d = '0;
                    pass_d      = 1'b0;
                    state_d     = WRITE;
                end
            end

            WRITE: begin
                aw_pend_d = aw_pend_q & ~M00_AXI_AWREADY;
                w_pend_d  = w_pend_q  & ~M00_AXI_WREADY;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WRESP;
                end else if (tmo_expired) begin
                    fail_set   = 1'b1;
                    fail_code  = ERR_DATA_TMO;
                    fail_rdata = TIMEOUT_RDATA;
                end
            end

            WRESP: begin
                if (M00_AXI_BVALID) begin
                    if (M00_AXI_BRESP != RESP_OKAY) begin
                        fail_set  = 1'b1;
                        fail_code = ERR_BRESP;
                    end else begin
                        state_d = READ;
                    end
                end else if (tmo_expired) begin
                    fail_set   = 1'b1;
                    fail_code  = ERR_DATA_TMO;
                    fail_rdata = TIMEOUT_RDATA;
                end
            end

            READ: begin
                if (M00_AXI_ARREADY) begin
                    state_d = RDATA;
                end else if (tmo_expired) begin
                    fail_set   = 1'b1;
                    fail_code  = ERR_DATA_TMO;
                    fail_rdata = TIMEOUT_RDATA;
                end
            end

            RDATA: begin
                if (M00_AXI_RVALID) begin
                    if (M00_AXI_RRESP != RESP_OKAY) begin
                        fail_set   = 1'b1;
                        fail_code  = ERR_RRESP;
                        fail_rdata = 32'(M00_AXI_RDATA);
                    end else if (M00_AXI_RDATA != C_M_AXI_DATA_WIDTH'(pat.data)) begin
                        fail_set   = 1'b1;
                        fail_code  = ERR_DATA_TMO;
                        fail_rdata = 32'(M00_AXI_RDATA);
                    end else begin
                        state_d = NEXT;
                    end
                end else if (tmo_expired) begin
                    fail_set   = 1'b1;
                    fail_code  = ERR_DATA_TMO;
                    fail_rdata = TIMEOUT_RDATA;
                end
            end

            NEXT: begin
                if (idx_q == 8'(C_NUM_REGS - 1)) begin
                    state_d = FIN;
                end else begin
                    idx_d     = idx_q + 8'd1;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = WRITE;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail_set) begin
            err_code_d  = fail_code;
            err_index_d = idx_q;
            err_rdata_d = fail_rdata;
            aw_pend_d   = 1'b0;
            w_pend_d    = 1'b0;
            state_d     = FIN;
        end

        // pass is settled on the way into FIN so it is already valid in the
        // cycle where done pulses.
        if (state_d == FIN && state_q != FIN) begin
            pass_d = (err_code_d == ERR_NONE);
        end

        // The timeout counter restarts on every state change, including the
        // NEXT -> WRITE hop, and only advances in the four waiting states.
        waiting = (state_q == WRITE) || (state_q == WRESP) ||
                  (state_q == READ)  || (state_q == RDATA);
        if (state_d != state_q || !waiting) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // AXI and status outputs are decoded from registered state only, so
    // they fall to zero the moment reset forces IDLE.
    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == FIN);
        pass            = pass_q;
        err_code        = err_code_q;
        err_index       = err_index_q;
        err_rdata       = err_rdata_q;

        M00_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'(pat.addr);
        M00_AXI_AWPROT  = 3'b000;
        M00_AXI_AWVALID = (state_q == WRITE) && aw_pend_q;

        M00_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(pat.data);
        M00_AXI_WSTRB   = 4'hF;
        M00_AXI_WVALID  = (state_q == WRITE) && w_pend_q;

        M00_AXI_BREADY  = (state_q == WRESP);

        M00_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(pat.addr);
        M00_AXI_ARPROT  = 3'b000;
        M00_AXI_ARVALID = (state_q == READ);

        M00_AXI_RREADY  = (state_q == RDATA);
    end

endmodule

// File: tb/tb_axil_regtest_master.sv
// -----------------------------------------------------------------------------
// tb_axil_regtest_master
//
// Directed bench for axil_regtest_master with a reactive AXI4-Lite slave
// model. The slave stores writes in a small memory, returns them on reads,
// and can inject ready delays, a bad BRESP, corrupted read data, or a
// missing ARREADY. It also tracks protocol rules seen on the bus.
// -----------------------------------------------------------------------------
module tb_axil_regtest_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [1:0]  err_code;
    logic [7:0]  err_index;
    logic [31:0] err_rdata;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int checks   = 0;
    int failures = 0;

    // Slave configuration, written by the main sequence only.
    int aw_delay    = 0;
    int w_delay     = 0;
    int rand_r      = 0;
    int corrupt_idx = -1;
    int bad_b_idx   = -1;
    int ar_never    = 0;
    int test_id     = 0;

    // Slave bookkeeping, written by the slave process only.
    logic [31:0] mem [0:63];
    int wr_cnt, rd_cnt, wr_c_cnt, rd_c_cnt;
    int hold_viol, overlap_viol, rise_viol, prot_viol, ar_hi_cnt;

    // Results captured by applyStimulus.
    int          run_cycles;
    logic        got_done;
    logic        res_pass;
    logic [1:0]  res_code;
    logic [7:0]  res_index;
    logic [31:0] res_rdata;
    logic        after_done, after_busy;

    always #5 clk = ~clk;

    axil_regtest_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (32'h0),
        .C_NUM_REGS         (4),
        .C_TIMEOUT          (255)
    ) dut (
        .M00_AXI_ACLK    (clk),
        .M00_AXI_ARESETN (rst_n),
        .start           (start),
        .seed            (seed),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_code        (err_code),
        .err_index       (err_index),
        .err_rdata       (err_rdata),
        .M00_AXI_AWADDR  (awaddr),
        .M00_AXI_AWPROT  (awprot),
        .M00_AXI_AWVALID (awvalid),
        .M00_AXI_AWREADY (awready),
        .M00_AXI_WDATA   (wdata),
        .M00_AXI_WSTRB   (wstrb),
        .M00_AXI_WVALID  (wvalid),
        .M00_AXI_WREADY  (wready),
        .M00_AXI_BRESP   (bresp),
        .M00_AXI_BVALID  (bvalid),
        .M00_AXI_BREADY  (bready),
        .M00_AXI_ARADDR  (araddr),
        .M00_AXI_ARPROT  (arprot),
        .M00_AXI_ARVALID (arvalid),
        .M00_AXI_ARREADY (arready),
        .M00_AXI_RDATA   (rdata),
        .M00_AXI_RRESP   (rresp),
        .M00_AXI_RVALID  (rvalid),
        .M00_AXI_RREADY  (rready)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every DUT output that reset must clear, packed into one vector.
    function automatic logic [63:0] resetVector();
        return 64'({busy, done, pass, err_code, err_index, err_rdata,
                    awvalid, wvalid, bready, arvalid, rready});
    endfunction

    // Pulses start, optionally pulses a second start at run cycle
    // restart_at (which must be ignored), and waits for done with a budget.
    // Cycle 1 is the first cycle after start is accepted.
    task automatic applyStimulus(input logic [31:0] s, input int restart_at);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        run_cycles = 1;
        got_done   = 1'b0;
        while (!got_done && run_cycles < 2000) begin
            if (done) begin
                got_done  = 1'b1;
                res_pass  = pass;
                res_code  = err_code;
                res_index = err_index;
                res_rdata = err_rdata;
            end else begin
                start = (run_cycles == restart_at);
                if (start) seed = 32'h0;
                @(negedge clk);
                run_cycles++;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 64'(got_done), 64'd1);
        @(negedge clk);
        after_done = done;
        after_busy = busy;
    endtask

    // Reactive slave. Handshakes are sampled at the rising edge; responses
    // and readies are driven at the following falling edge.
    logic        aw_got, w_got, b_pend, b_bad, r_pend;
    logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic        p_aw, p_w, p_ar, prev_awv;
    logic [31:0] aw_a, w_d, ar_a, p_awaddr, p_wdata, p_araddr;
    int          r_cnt, aw_seen, w_seen, last_id;

    initial begin : slave
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_bad = 0; r_pend = 0;
        p_aw = 0; p_w = 0; p_ar = 0; prev_awv = 0;
        aw_a = 0; w_d = 0; ar_a = 0; p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        r_cnt = 0; aw_seen = 0; w_seen = 0; last_id = -1;
        forever begin
            @(posedge clk);
            if (test_id != last_id) begin
                last_id = test_id;
                for (int i = 0; i < 64; i++) mem[i] = 32'h0;
                wr_cnt = 0; rd_cnt = 0; wr_c_cnt = 0; rd_c_cnt = 0;
                hold_viol = 0; overlap_viol = 0; rise_viol = 0;
                prot_viol = 0; ar_hi_cnt = 0;
            end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                p_aw = 0; p_w = 0; p_ar = 0; prev_awv = 0;
                aw_seen = 0; w_seen = 0;
                hs_b = 0; hs_r = 0;
            end else begin
                if (p_aw && (!awvalid || awaddr != p_awaddr)) hold_viol++;
                if (p_w  && (!wvalid  || wdata  != p_wdata))  hold_viol++;
                if (p_ar && (!arvalid || araddr != p_araddr)) hold_viol++;
                if (awvalid && !prev_awv && !wvalid) rise_viol++;
                if (arvalid && (awvalid || wvalid || aw_got || w_got || b_pend || bvalid))
                    overlap_viol++;
                if ((awvalid || wvalid) && (r_pend || rvalid)) overlap_viol++;
                if ((awvalid && awprot != 3'b000) || (wvalid && wstrb != 4'hF) ||
                    (arvalid && arprot != 3'b000)) prot_viol++;
                if (arvalid) ar_hi_cnt++;

                p_aw = awvalid && !awready; p_awaddr = awaddr;
                p_w  = wvalid  && !wready;  p_wdata  = wdata;
                p_ar = arvalid && !arready; p_araddr = araddr;
                prev_awv = awvalid;
                aw_seen = (awvalid && !hs_aw) ? aw_seen + 1 : 0;
                w_seen  = (wvalid  && !hs_w)  ? w_seen + 1  : 0;

                if (hs_aw) begin aw_a = awaddr; aw_got = 1; end
                if (hs_w)  begin w_d  = wdata;  w_got  = 1; end
                if (aw_got && w_got) begin
                    mem[aw_a[7:2]] = w_d;
                    wr_cnt++;
                    if (aw_a == 32'hC) wr_c_cnt++;
                    b_pend = 1;
                    b_bad  = (int'(aw_a[9:2]) == bad_b_idx);
                    aw_got = 0;
                    w_got  = 0;
                end
                if (hs_ar) begin
                    ar_a   = araddr;
                    r_pend = 1;
                    r_cnt  = (rand_r != 0) ? int'($urandom_range(0, 5)) : 0;
                    rd_cnt++;
                    if (araddr == 32'hC) rd_c_cnt++;
                end
            end

            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (hs_b) bvalid = 0;
                if (b_pend) begin
                    bvalid = 1;
                    bresp  = b_bad ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
                if (hs_r) rvalid = 0;
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        rvalid = 1;
                        rresp  = 2'b00;
                        rdata  = mem[ar_a[7:2]] ^
                                 {31'd0, (int'(ar_a[9:2]) == corrupt_idx)};
                        r_pend = 0;
                    end else begin
                        r_cnt--;
                    end
                end
                awready = awvalid && (aw_seen >= aw_delay);
                wready  = wvalid  && (w_seen  >= w_delay);
                arready = arvalid && (ar_never == 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int n;
        rst_n = 1'b1;
        start = 1'b0;
        seed  = 32'h0;

        // Power-up reset: outputs must clear without any clock edge.
        #1 rst_n = 1'b0;
        #1 checkOutput("reset_outputs", resetVector(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("idle_after_reset", 64'({busy, done}), 64'd0);

        // Zero-wait slave, seed 0101FFFF.
        test_id++;
        applyStimulus(32'h0101FFFF, 0);
        checkOutput("zw_cycles",   64'(run_cycles), 64'd21);
        checkOutput("zw_pass",     64'(res_pass),   64'd1);
        checkOutput("zw_err_code", 64'(res_code),   64'd0);
        checkOutput("zw_mem0",     64'(mem[0]),     64'h0101FFFF);
        checkOutput("zw_mem1",     64'(mem[1]),     64'h0000FEFE);
        checkOutput("zw_mem2",     64'(mem[2]),     64'h0303FDFD);
        checkOutput("zw_mem3",     64'(mem[3]),     64'h0202FCFC);
        checkOutput("zw_wr_cnt",   64'(wr_cnt),     64'd4);
        checkOutput("zw_rd_cnt",   64'(rd_cnt),     64'd4);
        checkOutput("zw_done_pulse", 64'({after_done, after_busy}), 64'd0);
        checkOutput("zw_overlap",  64'(overlap_viol), 64'd0);
        checkOutput("zw_rise",     64'(rise_viol),  64'd0);
        checkOutput("zw_prot",     64'(prot_viol),  64'd0);
        checkOutput("zw_pass_held", 64'(pass),      64'd1);

        // AWREADY leads WREADY by 3 cycles, random read latency, and a
        // start pulse mid-run that must be ignored.
        test_id++;
        w_delay = 3;
        rand_r  = 1;
        applyStimulus(32'h0101FFFF, 7);
        checkOutput("slow_pass",    64'(res_pass),   64'd1);
        checkOutput("slow_mem0",    64'(mem[0]),     64'h0101FFFF);
        checkOutput("slow_mem3",    64'(mem[3]),     64'h0202FCFC);
        checkOutput("slow_wr_cnt",  64'(wr_cnt),     64'd4);
        checkOutput("slow_hold",    64'(hold_viol),  64'd0);
        checkOutput("slow_overlap", 64'(overlap_viol), 64'd0);
        checkOutput("slow_longer",  64'(run_cycles >= 33), 64'd1);
        w_delay = 0;
        rand_r  = 0;

        // Register 2 reads back with bit 0 flipped.
        test_id++;
        corrupt_idx = 2;
        applyStimulus(32'h0101FFFF, 0);
        checkOutput("mis_pass",      64'(res_pass),  64'd0);
        checkOutput("mis_err_code",  64'(res_code),  64'd3);
        checkOutput("mis_err_index", 64'(res_index), 64'd2);
        checkOutput("mis_err_rdata", 64'(res_rdata), 64'h0303FDFC);
        checkOutput("mis_no_wr_c",   64'(wr_c_cnt),  64'd0);
        checkOutput("mis_no_rd_c",   64'(rd_c_cnt),  64'd0);
        checkOutput("mis_wr_cnt",    64'(wr_cnt),    64'd3);
        corrupt_idx = -1;

        // SLVERR on the write response of register 1.
        test_id++;
        bad_b_idx = 1;
        applyStimulus(32'hA5A5_0000, 0);
        checkOutput("bresp_pass",      64'(res_pass),  64'd0);
        checkOutput("bresp_err_code",  64'(res_code),  64'd1);
        checkOutput("bresp_err_index", 64'(res_index), 64'd1);
        checkOutput("bresp_wr_cnt",    64'(wr_cnt),    64'd2);
        checkOutput("bresp_rd_cnt",    64'(rd_cnt),    64'd1);
        bad_b_idx = -1;

        // ARREADY never asserted: READ lasts exactly 255 cycles.
        test_id++;
        ar_never = 1;
        applyStimulus(32'h0101FFFF, 0);
        checkOutput("tmo_err_code",  64'(res_code),   64'd3);
        checkOutput("tmo_err_rdata", 64'(res_rdata),  64'hDEAD0000);
        checkOutput("tmo_err_index", 64'(res_index),  64'd0);
        checkOutput("tmo_ar_cycles", 64'(ar_hi_cnt),  64'd255);
        checkOutput("tmo_cycles",    64'(run_cycles), 64'd258);
        checkOutput("tmo_rd_cnt",    64'(rd_cnt),     64'd0);
        ar_never = 0;

        // Reset while idle clears the sticky error registers.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("idle_reset_clears", resetVector(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted in the middle of WRESP, then a clean rerun.
        test_id++;
        @(negedge clk);
        seed  = 32'h0101FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wresp_reached", 64'(bready), 64'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("wresp_async_reset", resetVector(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_id++;
        applyStimulus(32'h12345678, 0);
        checkOutput("rerun_cycles", 64'(run_cycles), 64'd21);
        checkOutput("rerun_pass",   64'(res_pass),   64'd1);
        checkOutput("rerun_mem0",   64'(mem[0]),     64'h12345678);
        checkOutput("rerun_mem1",   64'(mem[1]),     64'h13355779);
        checkOutput("rerun_mem2",   64'(mem[2]),     64'h1036547A);
        checkOutput("rerun_mem3",   64'(mem[3]),     64'h1137557B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
